// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation.
// Operands are widened by two bits so one signed recoder serves both modes.
module booth_radix4_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int W2 = WIDTH + 2;
  localparam int AW = W2 + 2;
  localparam int N  = W2 / 2;
  localparam int CW = $clog2(N + 1);
  localparam int RW = AW + W2 + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [W2-1:0]      q_q, q_d;
  logic [W2-1:0]      m_q, m_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [W2-1:0]        m_ext;
  logic [W2-1:0]        q_ext;
  logic [AW-1:0]        ma;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        a_sum;
  logic signed [RW-1:0] work;
  logic                 accept;

  always_comb begin
    m_ext = signed_mode
      ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
      : {2'b00, multiplicand};
    q_ext = signed_mode
      ? {{2{multiplier[WIDTH-1]}}, multiplier}
      : {2'b00, multiplier};
    ma = {{2{m_q[W2-1]}}, m_q};

    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend = ma;
      3'b011:         addend = ma << 1;
      3'b100:         addend = -(ma << 1);
      3'b101, 3'b110: addend = -ma;
      default:        addend = '0;
    endcase

    a_sum = a_q + addend;
    work  = $signed({a_sum, q_q, qm1_q}) >>> 2;
  end

  assign accept = start && (state_q != RUN);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (1'b1)
      accept: begin
        state_d = RUN;
        m_d     = m_ext;
        q_d     = q_ext;
        a_d     = '0;
        qm1_d   = 1'b0;
        cnt_d   = CW'(N);
      end
      (state_q == RUN): begin
        a_d   = work[RW-1 -: AW];
        q_d   = work[W2:1];
        qm1_d = work[0];
        cnt_d = cnt_q - CW'(1);
        // Last pass: the full product sits in {A,Q} after this shift.
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          product_d = work[2*WIDTH:1];
        end
      end
      (state_q == DONE && !start): begin
        state_d = IDLE;
      end
      default: begin
        if (state_q != IDLE && state_q != DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Bench for booth_radix4_mult: directed corners plus random operands
// checked against a plain integer multiply.
module tb_booth_radix4_mult;

  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               signed_mode = 1'b0;
  logic [WIDTH-1:0]   multiplicand = '0;
  logic [WIDTH-1:0]   multiplier = '0;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int n_chk = 0;
  int n_err = 0;

  booth_radix4_mult #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic sm,
                                          input logic [15:0] m,
                                          input logic [15:0] q);
    longint a;
    longint b;
    longint p;
    a = sm ? longint'($signed(m)) : longint'(m);
    b = sm ? longint'($signed(q)) : longint'(q);
    p = a * b;
    return p[31:0];
  endfunction

  // One operation from IDLE; optionally disturbs start/operands mid-run.
  task automatic do_op(input string tag, input logic sm,
                       input logic [15:0] m, input logic [15:0] q,
                       input logic [31:0] exp, input bit scramble);
    int bc;
    int dn;
    @(negedge clk);
    start = 1'b1;
    signed_mode = sm;
    multiplicand = m;
    multiplier = q;
    @(negedge clk);
    bc = 0;
    dn = 0;
    for (int i = 0; i < 9; i++) begin
      if (busy) bc++;
      if (done) dn++;
      if (scramble && i < 8) begin
        start = 1'($urandom);
        signed_mode = 1'($urandom);
        multiplicand = 16'($urandom);
        multiplier = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, ".busy_cycles"}, 64'(bc), 64'd9);
    chk({tag, ".early_done"}, 64'(dn), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, ".product"}, 64'(product), 64'(exp));
    @(negedge clk);
    chk({tag, ".done_once"}, 64'(done), 64'd0);
    chk({tag, ".product_hold"}, 64'(product), 64'(exp));
  endtask

  initial begin
    logic [15:0] m;
    logic [15:0] q;
    logic        sm;
    int          d1;
    int          d2;
    int          dcount;
    logic [31:0] p1;
    logic [31:0] p2;

    #12;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("s3xm4", 1'b1, 16'd3, 16'hFFFC, 32'hFFFFFFF4, 1'b0);
    do_op("uffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0);
    do_op("sffff", 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0);
    do_op("s8k8k", 1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b0);
    do_op("s8k7f", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, 1'b0);
    do_op("s0x8k", 1'b1, 16'h0000, 16'h8000, 32'h00000000, 1'b0);
    do_op("u8k8k", 1'b0, 16'h8000, 16'h8000, 32'h40000000, 1'b0);
    do_op("scram", 1'b1, 16'd1234, 16'hFF00,
          ref_mul(1'b1, 16'd1234, 16'hFF00), 1'b1);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1;
    signed_mode = 1'b1;
    multiplicand = 16'd5;
    multiplier = 16'd7;
    @(negedge clk);
    multiplicand = 16'hFFFE;
    multiplier = 16'd9;
    d1 = 0;
    d2 = 0;
    dcount = 0;
    p1 = '0;
    p2 = '0;
    for (int c = 1; c <= 21; c++) begin
      if (done) begin
        dcount++;
        if (d1 == 0) begin
          d1 = c;
          p1 = product;
        end else if (d2 == 0) begin
          d2 = c;
          p2 = product;
        end
      end
      if (c == 15) chk("b2b.hold", 64'(product), 64'd35);
      if (c == 20) start = 1'b0;
      @(negedge clk);
    end
    chk("b2b.d1", 64'(d1), 64'd10);
    chk("b2b.d2", 64'(d2), 64'd20);
    chk("b2b.p1", 64'(p1), 64'd35);
    chk("b2b.p2", 64'(p2), 64'(32'hFFFFFFEE));
    chk("b2b.count", 64'(dcount), 64'd2);

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    signed_mode = 1'b0;
    multiplicand = 16'd100;
    multiplier = 16'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    chk("arst.product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) dcount++;
      @(negedge clk);
    end
    chk("arst.no_done", 64'(dcount), 64'd0);
    do_op("post_rst", 1'b1, 16'hFFF9, 16'd6, 32'hFFFFFFD6, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sm = 1'($urandom);
      m = 16'($urandom);
      q = 16'($urandom);
      if (i % 8 == 0) m = 16'h8000;
      if (i % 8 == 1) q = 16'hFFFF;
      do_op($sformatf("rnd%0d", i), sm, m, q,
            ref_mul(sm, m, q), (i % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/booth_radix4_mult.md
# booth_radix4_mult

Parametrised, sequential radix-4 Booth multiplier. It is the next generation of the team's 16-bit radix-2 Booth datapath/controller pair, merged into a single block.
- Operands are presented in parallel and captured on one start strobe, rather than loaded serially over a shared data bus.
- Signed and unsigned operation are both supported, selected per operation.
- Two multiplier bits are retired per cycle.
- It sits behind any register-mapped or streaming front end that needs a small-area multiplier with bounded, fixed latency.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted when busy is low
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- multiplicand  input  WIDTH  operand M; sampled with start
- multiplier  input  WIDTH  operand Q; sampled with start
- busy  output  1  high while an operation is in progress (state RUN)
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  result; held until the next done

## Operation
- Internal operand width is W2 = WIDTH+2.
  - signed_mode=1: M and Q are sign-extended to W2.
  - signed_mode=0: M and Q are zero-extended to W2.
  - The same signed algorithm then serves both modes.
- Iteration count is N = W2/2 = WIDTH/2+1.
- Accumulator A is W2+2 bits so that ±2M never overflows. The working register is {A, Q, q_m1}.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE with start=1 → RUN. On this accept edge: capture M, Q and mode; A=0; q_m1=0; cnt=N.
  - RUN, each cycle: recode {Q[1],Q[0],q_m1} and update A as follows:
    - 000, 111 → +0
    - 001, 010 → +M
    - 011 → +2M
    - 100 → −2M
    - 101, 110 → −M
  - RUN, same cycle: arithmetic-shift {A,Q,q_m1} right by 2, then decrement cnt.
  - RUN with cnt reaching 0 after the update → DONE. On this edge, product is loaded with the low 2*WIDTH bits of {A,Q}.
  - DONE with start=1 → RUN: a new operation is captured, allowing back-to-back operation.
  - DONE with start=0 → IDLE.
- start while busy=1 is ignored. Operands are not re-sampled and the operation in flight is not disturbed.
- Operand or signed_mode changes after the accept edge have no effect.
- The result is exact in both modes: the signed product, or the unsigned product, of the sampled operands. No truncation occurs, since 2*WIDTH bits always suffice.
- product changes only on the DONE-entry edge and on reset.

## Timing
- Reset (rst_n low, asynchronous, at any time including mid-RUN):
  - state=IDLE, busy=0, done=0, product=0.
  - Internal A, Q, cnt and q_m1 are cleared.
  - No done is produced for the aborted operation.
- After rst_n deasserts, the first start is accepted on the first rising edge at which it is sampled high.
- Latency:
  - start is accepted at edge E0.
  - busy is high for exactly N cycles, after edges E0 … E(N−1).
  - done is high for exactly one cycle, after edge EN.
  - For WIDTH=16: N=9, and done is high in the 10th cycle after the accept edge.
- Throughput: one result every N+1 cycles when start is held high continuously, including acceptance in the DONE cycle.
- done is never asserted on two consecutive cycles.
- busy and done are never high together.

## Test plan
- WIDTH=16, signed_mode=1, M=3, Q=−4, single start pulse → busy high for 9 cycles, then done for 1 cycle; product=32'hFFFFFFF4 (−12).
- signed_mode=0, M=16'hFFFF, Q=16'hFFFF → product=32'hFFFE0001. Repeat with signed_mode=1 → product=32'h00000001.
- signed_mode=1 corner cases:
  - M=Q=16'h8000 → 32'h40000000.
  - M=16'h8000, Q=16'h7FFF → 32'hC0008000.
  - M=0, Q=16'h8000 → 0.
- Pulse start with new operands during RUN, and change operands after acceptance → first result unaffected; no extra done is produced.
- Hold start high with operand pairs (5,7) and then (−2,9) → two done pulses 10 cycles apart, with product 35 and then −18. product holds 35 between the two pulses.
- Assert rst_n low asynchronously mid-RUN (between edges) → busy, done and product read 0 immediately. No done follows. A fresh start after release gives the correct result at the nominal latency.
